bcd_adder_serial: RTL and testbench

//  Digit-serial, multi-digit packed-BCD adder/subtractor with valid/ready handshake.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_adder_serial_if.sv | 40 ++++
 rtl/bcd_digit_add.sv | 29 ++
 rtl/bcd_adder_serial.sv | 128 ++++++++++++
 tb/tb_bcd_adder_serial.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder/subtractor.
// Imported by the digit slice and the top level.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Subtraction adds the nines complement of each B digit.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t x);
        return BCD_MAX - x;
    endfunction

endpackage

// File: rtl/bcd_adder_serial_if.sv
// Operand/result handshake bundle for bcd_adder_serial.
// The out_err signal exists only when BCD_INVALID_CHECK_EN is defined.
interface bcd_adder_serial_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int W = 4 * NUM_DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
`ifdef BCD_INVALID_CHECK_EN
    logic         out_err;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, out_err
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, out_err
    );
`else
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out
    );
`endif

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD slice: binary add of two digits and a carry,
// then +6 correction when the raw sum exceeds nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    output bcd_digit_t d,
    output logic       cout
);

    logic [4:0] t;
    logic [4:0] t_corr;

    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        t      = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        t_corr = t + {1'b0, BCD_CORR};
        if (t > {1'b0, BCD_MAX}) begin
            d    = t_corr[3:0];
            cout = 1'b1;
        end else begin
            d    = t[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_INVALID_CHECK_EN to add the out_err invalid-digit flag.
module bcd_adder_serial
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_adder_serial_if.slave   bus
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          sub_q;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  s_q;
    logic          c_out_q;

    bcd_digit_t y_dig;
    bcd_digit_t d_dig;
    logic       d_cout;

    assign y_dig = sub_q ? nines_comp(b_sh[3:0]) : b_sh[3:0];

    bcd_digit_add u_slice (
        .x    (a_sh[3:0]),
        .y    (y_dig),
        .cin  (carry),
        .d    (d_dig),
        .cout (d_cout)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;

`ifdef BCD_INVALID_CHECK_EN
    logic err_pend;
    logic out_err_q;

    assign bus.out_err = out_err_q;

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sub_q       <= 1'b0;
            carry       <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            err_pend    <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        sub_q      <= bus.sub;
                        // Subtraction is a + nines(b) + 1 - borrow, so the borrow enters inverted.
                        carry      <= bus.sub ? ~bus.c_in : bus.c_in;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
`ifdef BCD_INVALID_CHECK_EN
                        err_pend   <= has_invalid(bus.a) | has_invalid(bus.b);
`endif
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    // Result digits enter at the top; after NUM_DIGITS shifts digit 0 sits in [3:0].
                    s_q   <= (s_q >> 4) | (W'(d_dig) << (W - 4));
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_out_q     <= d_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef BCD_INVALID_CHECK_EN
                        out_err_q   <= err_pend;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
`ifdef BCD_INVALID_CHECK_EN
                        out_err_q   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Self-checking bench for bcd_adder_serial: directed cases plus randomized
// operands scored against a decimal-integer reference model.
module tb_bcd_adder_serial;

    localparam int N = 4;
    localparam int M = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_adder_serial_if #(.NUM_DIGITS(N)) bus ();
    bcd_adder_serial_if #(.NUM_DIGITS(1)) bus1 ();

    bcd_adder_serial #(.NUM_DIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bcd_adder_serial #(.NUM_DIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: plain decimal arithmetic modulo 10^N.
    task automatic model(input int av, input int bv, input bit cin, input bit sb,
                         output logic [15:0] s_exp, output logic c_exp);
        int r;
        if (!sb) begin
            r     = av + bv + int'(cin);
            c_exp = (r >= M);
            s_exp = to_bcd(r % M);
        end else begin
            r     = av - bv - int'(cin);
            c_exp = (r >= 0);
            s_exp = to_bcd(r < 0 ? r + M : r);
        end
    endtask

    // Presents operands, waits for accept, then waits for out_valid (no handshake).
    task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv,
                                  input logic cin, input logic sb, output int lat);
        int guard;
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.c_in = cin; bus.sub = sb; bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_low"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ir_high"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_check(input string tag, input int av, input int bv,
                             input bit cin, input bit sb, input bit chk_lat);
        logic [15:0] s_exp;
        logic        c_exp;
        int          lat;
        model(av, bv, cin, sb, s_exp, c_exp);
        start_and_wait(to_bcd(av), to_bcd(bv), cin, sb, lat);
        check({tag, "_s"}, 32'(bus.s), 32'(s_exp));
        check({tag, "_c"}, 32'(bus.c_out), 32'(c_exp));
        if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'(N + 1));
        handshake(tag);
    endtask

    initial begin
        logic [15:0] s_hold;
        logic        c_hold;
        int          lat;
        int          av, bv;
        bit          cin, sb;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.sub = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_check("add_1234_5678", 1234, 5678, 1'b0, 1'b0, 1'b1);
        run_check("add_9999_0001", 9999, 1, 1'b0, 1'b0, 1'b1);
        run_check("sub_5000_1234", 5000, 1234, 1'b0, 1'b1, 1'b1);
        run_check("sub_0000_0001", 0, 1, 1'b0, 1'b1, 1'b0);
        run_check("add_cin_wrap", 9999, 9999, 1'b1, 1'b0, 1'b0);
        run_check("sub_borrow_eq", 1235, 1234, 1'b1, 1'b1, 1'b0);

        // Back-pressure in DONE: outputs stable, in_valid pulses ignored
        start_and_wait(16'h0042, 16'h0017, 1'b0, 1'b0, lat);
        s_hold = bus.s;
        c_hold = bus.c_out;
        check("bp_first_s", 32'(s_hold), 32'h0059);
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'h7777; bus.b = 16'h1111; bus.in_valid = i[0] ? 1'b0 : 1'b1;
            @(negedge clk);
            check("bp_s_stable", 32'(bus.s), 32'(s_hold));
            check("bp_c_stable", 32'(bus.c_out), 32'(c_hold));
            check("bp_ov_stable", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        handshake("bp");

        // Asynchronous reset during RUN digit 2
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h5678; bus.c_in = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_s", 32'(bus.s), 32'd0);
        check("abort_c_out", 32'(bus.c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_abort", 1, 1, 1'b0, 1'b0, 1'b1);

        // Randomized operands against the decimal model
        for (int i = 0; i < 25; i++) begin
            av  = int'($urandom_range(0, M - 1));
            bv  = int'($urandom_range(0, M - 1));
            cin = 1'($urandom_range(0, 1));
            sb  = 1'($urandom_range(0, 1));
            run_check("rand", av, bv, cin, sb, 1'b1);
        end

        // Single-digit instance: 9+9+1 and 3-5
        @(negedge clk);
        bus1.a = 4'd9; bus1.b = 4'd9; bus1.c_in = 1'b1; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("nd1_add_lat", 32'(lat), 32'd2);
        check("nd1_add_s", 32'(bus1.s), 32'd9);
        check("nd1_add_c", 32'(bus1.c_out), 32'd1);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        bus1.a = 4'd3; bus1.b = 4'd5; bus1.c_in = 1'b0; bus1.sub = 1'b1; bus1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("nd1_sub_s", 32'(bus1.s), 32'd8);
        check("nd1_sub_c", 32'(bus1.c_out), 32'd0);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;

`ifdef BCD_INVALID_CHECK_EN
        start_and_wait(16'h12A4, 16'h0001, 1'b0, 1'b0, lat);
        check("err_set_ov", 32'(bus.out_valid), 32'd1);
        check("err_set", 32'(bus.out_err), 32'd1);
        handshake("err");
        check("err_cleared", 32'(bus.out_err), 32'd0);
        start_and_wait(16'h1234, 16'h0001, 1'b0, 1'b0, lat);
        check("err_clean_op", 32'(bus.out_err), 32'd0);
        handshake("err_clean");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
